system_wrapper: RTL and testbench

SYSTEM_WRAPPER -- requirements
Module: system_wrapper

---
 rtl/system_wrapper.sv | 189 ++++++++++++++++++
 tb/tb_system_wrapper.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_wrapper.sv
// Triangle fetch engine: pops ray requests, reads triangle lines over AXI4,
// parks leading triangles in a BRAM and returns the last one as a response.
module system_wrapper #(
  parameter int ID_WIDTH = 5,
  parameter int NUM_TRIGS_WIDTH = 3,
  parameter int TRIG_IDX_WIDTH = 29,
  parameter int TRIG_BYTES = 36,
  parameter int ADDR_WIDTH = 36,
  parameter logic [ADDR_WIDTH-1:0] TRIG_BASE_ADDR = 36'h8_4000_0000,
  parameter int AXI_DATA_WIDTH = 512,
  localparam int TRIG_WIDTH = TRIG_BYTES * 8,
  localparam int REQ_WIDTH = TRIG_IDX_WIDTH + NUM_TRIGS_WIDTH + ID_WIDTH,
  localparam int BRAM_AW = NUM_TRIGS_WIDTH + ID_WIDTH
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [REQ_WIDTH-1:0]         ist_mem_req_din,
  input  logic                         ist_mem_req_empty,
  output logic                         ist_mem_req_read,
  output logic [TRIG_WIDTH+ID_WIDTH-1:0] ist_mem_resp_dout,
  input  logic                         ist_mem_resp_full,
  output logic                         ist_mem_resp_write,
  input  logic                         enb,
  input  logic [BRAM_AW-1:0]           addrb,
  output logic [TRIG_WIDTH-1:0]        doutb,
  output logic [ADDR_WIDTH-1:0]        m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  output logic [2:0]                   m_axi_arsize,
  output logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]    m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rlast,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready
);

  localparam int LINE_BYTES = AXI_DATA_WIDTH / 8;
  localparam int LB = $clog2(LINE_BYTES);
  localparam int OFF_W = LB + 4;
  localparam int NW = NUM_TRIGS_WIDTH;
  localparam int DEPTH = ((1 << NW) - 2) << ID_WIDTH;
  localparam logic [NW-1:0] ONE = NW'(1);
  localparam logic [NW-1:0] TWO = NW'(2);

  typedef enum logic [2:0] {
    IDLE, POP, ADDR, DATA, EXTRACT, RESP
  } state_t;

  state_t state, state_nx;

  logic [ID_WIDTH-1:0]       id;
  logic [NW-1:0]             num, k;
  logic [ADDR_WIDTH-1:0]     cur_addr, line, addr0;
  logic [2*AXI_DATA_WIDTH-1:0] window, shifted;
  logic [OFF_W-1:0]          off;
  logic                      fits, last, bram_we;
  logic [TRIG_WIDTH-1:0]     trig;
  logic [NW-1:0]             slot;
  logic [BRAM_AW-1:0]        bram_addr;
  logic [TRIG_WIDTH-1:0]     mem [0:DEPTH-1];

  logic [ID_WIDTH-1:0]       req_id;
  logic [NW-1:0]             req_num;
  logic [TRIG_IDX_WIDTH-1:0] req_idx;

  assign req_id  = ist_mem_req_din[ID_WIDTH-1:0];
  assign req_num = ist_mem_req_din[ID_WIDTH+NW-1:ID_WIDTH];
  assign req_idx = ist_mem_req_din[REQ_WIDTH-1:ID_WIDTH+NW];

  assign addr0 = TRIG_BASE_ADDR
               + ADDR_WIDTH'(req_idx) * ADDR_WIDTH'(TRIG_BYTES);

  // window holds {current line, previous line}; off is relative to prev
  assign off = cur_addr[OFF_W-1:0] - line[OFF_W-1:0]
             + OFF_W'(LINE_BYTES);
  assign fits = (off + OFF_W'(TRIG_BYTES)) <= OFF_W'(2 * LINE_BYTES);
  assign shifted = window >> {off, 3'b000};
  assign trig = shifted[TRIG_WIDTH-1:0];
  assign last = (k == num - ONE);
  assign slot = num - TWO - k;
  assign bram_addr = {slot, id};

  assign m_axi_araddr  = line;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(LB);
  assign m_axi_arburst = 2'b01;

  logic unused_bits;
  assign unused_bits = ^{cur_addr[ADDR_WIDTH-1:OFF_W],
                         shifted[2*AXI_DATA_WIDTH-1:TRIG_WIDTH],
                         m_axi_rresp, m_axi_rlast};

  // state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  // next state and handshake outputs
  always_comb begin
    state_nx           = state;
    ist_mem_req_read   = 1'b0;
    ist_mem_resp_write = 1'b0;
    m_axi_arvalid      = 1'b0;
    m_axi_rready       = 1'b0;
    bram_we            = 1'b0;
    unique case (state)
      IDLE: if (!ist_mem_req_empty) state_nx = POP;
      POP: begin
        ist_mem_req_read = 1'b1;
        state_nx = (req_num == '0) ? IDLE : ADDR;
      end
      ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nx = DATA;
      end
      DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_nx = EXTRACT;
      end
      EXTRACT: begin
        if (k == num)  state_nx = RESP;
        else if (!fits) state_nx = ADDR;
        else bram_we = !last;
      end
      RESP: begin
        if (!ist_mem_resp_full) begin
          ist_mem_resp_write = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // request context, line window and response register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      id <= '0;
      num <= '0;
      k <= '0;
      cur_addr <= '0;
      line <= '0;
      window <= '0;
      ist_mem_resp_dout <= '0;
    end else begin
      unique case (state)
        POP: begin
          id <= req_id;
          num <= req_num;
          k <= '0;
          cur_addr <= addr0;
          line <= {addr0[ADDR_WIDTH-1:LB], {LB{1'b0}}};
        end
        DATA: begin
          if (m_axi_rvalid)
            window <= {m_axi_rdata,
                       window[2*AXI_DATA_WIDTH-1:AXI_DATA_WIDTH]};
        end
        EXTRACT: begin
          if (k != num) begin
            if (fits) begin
              k <= k + ONE;
              cur_addr <= cur_addr + ADDR_WIDTH'(TRIG_BYTES);
              if (last) ist_mem_resp_dout <= {trig, id};
            end else begin
              line <= line + ADDR_WIDTH'(LINE_BYTES);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // BRAM port A write; contents survive reset
  always_ff @(posedge aclk) begin
    if (bram_we) mem[bram_addr] <= trig;
  end

  // BRAM port B synchronous read, old data on collision
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  doutb <= '0;
    else if (enb)  doutb <= mem[addrb];
  end

endmodule

// File: tb/tb_system_wrapper.sv
// Self-checking bench for system_wrapper: random-delay AXI slave,
// byte-level memory model and randomized request sweep.
`timescale 1ns/1ps
module tb_system_wrapper;

  localparam logic [35:0] BASE = 36'h8_4000_0000;
  localparam int MEM_BYTES = 2048 * 36 + 256;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [36:0]  ist_mem_req_din = '0;
  logic         ist_mem_req_empty = 1'b1;
  logic         ist_mem_req_read;
  logic [292:0] ist_mem_resp_dout;
  logic         ist_mem_resp_full = 1'b0;
  logic         ist_mem_resp_write;
  logic         enb = 1'b0;
  logic [7:0]   addrb = '0;
  logic [287:0] doutb;
  logic [35:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arvalid;
  logic         m_axi_arready;
  logic [511:0] m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast;
  logic         m_axi_rvalid;
  logic         m_axi_rready;

  int checks = 0;
  int errors = 0;

  byte unsigned mem [MEM_BYTES];
  logic [287:0] bram_m [192];
  bit           bram_v [192];
  logic [35:0]  ar_q [$];
  logic [292:0] resp_q [$];
  bit           pop_q [$];

  system_wrapper dut (
    .aclk(aclk), .aresetn(aresetn),
    .ist_mem_req_din(ist_mem_req_din),
    .ist_mem_req_empty(ist_mem_req_empty),
    .ist_mem_req_read(ist_mem_req_read),
    .ist_mem_resp_dout(ist_mem_resp_dout),
    .ist_mem_resp_full(ist_mem_resp_full),
    .ist_mem_resp_write(ist_mem_resp_write),
    .enb(enb), .addrb(addrb), .doutb(doutb),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  function automatic logic [287:0] tri_at(logic [35:0] a);
    logic [287:0] t;
    longint o;
    o = longint'(a - BASE);
    for (int b = 0; b < 36; b++) t[b*8 +: 8] = mem[o + b];
    return t;
  endfunction

  function automatic logic [511:0] line_at(logic [35:0] a);
    logic [511:0] d;
    longint o;
    o = longint'(a - BASE);
    for (int b = 0; b < 64; b++)
      d[b*8 +: 8] = (o + b < MEM_BYTES) ? mem[o + b] : 8'h00;
    return d;
  endfunction

  // slave samples DUT outputs mid-cycle to avoid edge races
  logic        arv_s, rr_s;
  logic [35:0] aa_s, s_addr;
  int          sph, dly;

  always @(negedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arv_s <= 1'b0;
      rr_s <= 1'b0;
      aa_s <= '0;
    end else begin
      arv_s <= m_axi_arvalid;
      rr_s <= m_axi_rready;
      aa_s <= m_axi_araddr;
    end
  end

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sph <= 0;
      dly <= 0;
      s_addr <= '0;
      m_axi_arready <= 1'b0;
      m_axi_rvalid <= 1'b0;
      m_axi_rdata <= '0;
      m_axi_rresp <= 2'b00;
      m_axi_rlast <= 1'b0;
    end else begin
      case (sph)
        0: if (arv_s) begin
          dly <= int'($urandom_range(0, 7));
          sph <= 1;
        end
        1: if (dly == 0) begin
          m_axi_arready <= 1'b1;
          sph <= 2;
        end else dly <= dly - 1;
        2: begin
          m_axi_arready <= 1'b0;
          s_addr <= aa_s;
          dly <= int'($urandom_range(0, 7));
          sph <= 3;
        end
        3: if (dly == 0) begin
          m_axi_rvalid <= 1'b1;
          m_axi_rdata <= line_at(s_addr);
          m_axi_rresp <= 2'($urandom);
          m_axi_rlast <= 1'b1;
          sph <= 4;
        end else dly <= dly - 1;
        default: if (rr_s) begin
          m_axi_rvalid <= 1'b0;
          sph <= 0;
        end
      endcase
    end
  end

  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_axi_arvalid && m_axi_arready) ar_q.push_back(m_axi_araddr);
      if (ist_mem_resp_write) resp_q.push_back(ist_mem_resp_dout);
      if (ist_mem_req_read) pop_q.push_back(1'b1);
    end
  end

  task automatic issue(input int idx, input int n, input int id,
                       output bit ok);
    int w;
    ar_q.delete();
    resp_q.delete();
    pop_q.delete();
    @(posedge aclk); #1;
    ist_mem_req_din = {29'(idx), 3'(n), 5'(id)};
    ist_mem_req_empty = 1'b0;
    w = 0;
    while (pop_q.size() == 0 && w < 20) begin
      @(negedge aclk); #1;
      w++;
    end
    @(posedge aclk); #1;
    ist_mem_req_empty = 1'b1;
    checks++;
    ok = (pop_q.size() == 1);
    if (!ok) begin
      errors++;
      $display("FAIL pop idx=%0d n=%0d: pops %0d want 1",
               idx, n, pop_q.size());
    end
  endtask

  task automatic test_request(input int idx, input int n, input int id);
    logic [35:0] start, first;
    int nlines, w;
    bit ok;
    logic [292:0] exp;
    issue(idx, n, id, ok);
    if (!ok) return;
    start = BASE + 36'(idx) * 36'd36;
    if (n == 0) begin
      repeat (40) @(negedge aclk);
      #1;
      checks++;
      if (ar_q.size() != 0 || resp_q.size() != 0) begin
        errors++;
        $display("FAIL drop: ars %0d resps %0d want 0 0",
                 ar_q.size(), resp_q.size());
      end
      return;
    end
    first = start & ~36'd63;
    nlines = int'((((start + 36'(36 * n) - 1) & ~36'd63) - first) / 64) + 1;
    exp = {tri_at(start + 36'(36 * (n - 1))), 5'(id)};
    w = 0;
    while (resp_q.size() == 0 && w < 1000) begin
      @(negedge aclk); #1;
      w++;
    end
    repeat (5) @(negedge aclk);
    #1;
    checks++;
    if (resp_q.size() != 1) begin
      errors++;
      $display("FAIL resp_count idx=%0d n=%0d: got %0d want 1",
               idx, n, resp_q.size());
    end else begin
      checks++;
      if (resp_q[0] !== exp) begin
        errors++;
        $display("FAIL resp idx=%0d n=%0d id=%0d: got %h want %h",
                 idx, n, id, resp_q[0], exp);
      end
    end
    checks++;
    if (ar_q.size() != nlines) begin
      errors++;
      $display("FAIL ar_count idx=%0d n=%0d: got %0d want %0d",
               idx, n, ar_q.size(), nlines);
    end else begin
      for (int i = 0; i < nlines; i++) begin
        checks++;
        if (ar_q[i] !== first + 36'(64 * i)) begin
          errors++;
          $display("FAIL araddr idx=%0d line %0d: got %h want %h",
                   idx, i, ar_q[i], first + 36'(64 * i));
        end
      end
    end
    for (int k = 0; k < n - 1; k++) begin
      bram_m[(n - 2 - k) * 32 + id] = tri_at(start + 36'(36 * k));
      bram_v[(n - 2 - k) * 32 + id] = 1'b1;
    end
    for (int s = 0; s < 6; s++) begin
      if (bram_v[s * 32 + id]) begin
        @(posedge aclk); #1;
        enb = 1'b1;
        addrb = 8'(s * 32 + id);
        @(posedge aclk); #1;
        enb = 1'b0;
        checks++;
        if (doutb !== bram_m[s * 32 + id]) begin
          errors++;
          $display("FAIL bram addr=%0d: got %h want %h",
                   s * 32 + id, doutb, bram_m[s * 32 + id]);
        end
      end
    end
  endtask

  task automatic test_reset;
    ist_mem_req_din = 37'h1_2345_6789;
    ist_mem_req_empty = 1'b0;
    enb = 1'b1;
    addrb = 8'd3;
    repeat (3) @(negedge aclk);
    checks++;
    if ({ist_mem_req_read, ist_mem_resp_write,
         m_axi_arvalid, m_axi_rready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {ist_mem_req_read, ist_mem_resp_write,
                m_axi_arvalid, m_axi_rready});
    end
    checks++;
    if (ist_mem_resp_dout !== '0 || doutb !== '0) begin
      errors++;
      $display("FAIL reset_data: dout %h doutb %h want 0",
               ist_mem_resp_dout, doutb);
    end
    ist_mem_req_empty = 1'b1;
    enb = 1'b0;
    aresetn = 1'b1;
  endtask

  task automatic test_bram_hold;
    logic [287:0] held;
    test_request(100, 7, 9);
    @(posedge aclk); #1;
    enb = 1'b1;
    addrb = 8'(2 * 32 + 9);
    @(posedge aclk); #1;
    enb = 1'b0;
    held = bram_m[2 * 32 + 9];
    addrb = 8'(4 * 32 + 9);
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (doutb !== held) begin
      errors++;
      $display("FAIL bram_hold: got %h want %h", doutb, held);
    end
  endtask

  task automatic test_resp_full;
    logic [292:0] exp;
    bit ok;
    int bad;
    ist_mem_resp_full = 1'b1;
    issue(500, 6, 17, ok);
    exp = {tri_at(BASE + 36'(36 * 505)), 5'd17};
    repeat (300) @(negedge aclk);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (ist_mem_resp_write !== 1'b0 || ist_mem_resp_dout !== exp)
        bad++;
    end
    checks++;
    if (bad != 0 || resp_q.size() != 0) begin
      errors++;
      $display("FAIL full_hold: bad %0d writes %0d dout %h want %h",
               bad, resp_q.size(), ist_mem_resp_dout, exp);
    end
    @(posedge aclk); #1;
    ist_mem_resp_full = 1'b0;
    repeat (10) @(negedge aclk);
    #1;
    checks++;
    if (resp_q.size() != 1 || resp_q[0] !== exp) begin
      errors++;
      $display("FAIL full_release: writes %0d want 1", resp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int w;
    issue(1234, 7, 3, ok);
    w = 0;
    while (m_axi_rready !== 1'b1 && w < 100) begin
      @(negedge aclk);
      w++;
    end
    checks++;
    if (m_axi_rready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach_data: rready %b want 1", m_axi_rready);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if ({ist_mem_req_read, ist_mem_resp_write, m_axi_arvalid,
         m_axi_rready} !== 4'b0000 || ist_mem_resp_dout !== '0
        || doutb !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: ctrl %b dout %h",
               {ist_mem_req_read, ist_mem_resp_write, m_axi_arvalid,
                m_axi_rready}, ist_mem_resp_dout);
    end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (40) @(negedge aclk);
    #1;
    checks++;
    if (resp_q.size() != 0 || ist_mem_resp_write !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_resp: writes %0d want 0", resp_q.size());
    end
    test_request(777, 5, 3);
  endtask

  task automatic test_sweep;
    test_request(0, 7, 0);
    test_request(2041, 7, 30);
    test_request(2041, 1, 1);
    test_request(55, 0, 4);
    for (int i = 0; i < 110; i++)
      test_request(int'($urandom_range(0, 2041)),
                   int'($urandom_range(1, 7)),
                   int'($urandom_range(0, 31)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 192; i++) bram_v[i] = 1'b0;
    test_reset();
    test_request(0, 1, 5);
    test_request(1, 7, 31);
    test_bram_hold();
    test_resp_full();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
